agc_mem_sequencer: RTL and testbench

- Sits between the control unit and the erasable/fixed data memory; owns the memory's address, write-data and write-enable inputs and consumes its registered read data.
- Turns single-beat control-unit requests (read, write, increment) into correctly timed memory cycles.
- Applies AGC editing on writes to CYR/SR/CYL/EDOP, the zero-register rules and fixed-memory write protection.

---
 rtl/agc_mem_sequencer.sv | 135 +++++++++++++
 tb/tb_agc_mem_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_mem_sequencer.sv
// Memory sequencer between the AGC control unit and erasable/fixed memory:
// turns single-beat read/write/increment requests into timed memory cycles with editing and protection.
module agc_mem_sequencer #(
    parameter int AW      = 12,
    parameter int DW      = 15,
    parameter int MEM_TOP = 2046
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_e;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INC, OP_RSVD} op_e;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(7);
    localparam logic [AW-1:0] CYR_ADDR  = AW'(16);
    localparam logic [AW-1:0] SR_ADDR   = AW'(17);
    localparam logic [AW-1:0] CYL_ADDR  = AW'(18);
    localparam logic [AW-1:0] EDOP_ADDR = AW'(19);
    localparam logic [AW-1:0] TOP_ADDR  = AW'(MEM_TOP);

    state_e        state;
    state_e        next_state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rsp_data_q;
    logic          is_inc_q;
    logic          oor_q;
    logic          zero_q;
    logic          err_q;
    logic          suppress_q;

    logic          accept;
    logic          req_oor;
    logic          req_fixed;
    logic          req_zero;
    logic          req_stores;
    logic [DW-1:0] req_edited;
    logic [DW-1:0] cap_value;
    logic [DW-1:0] inc_value;

    // Editing registers rewrite the stored value; every other address stores it verbatim.
    function automatic logic [DW-1:0] edit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (a)
            CYR_ADDR:  edit = {d[0], d[DW-1:1]};
            SR_ADDR:   edit = {d[DW-1], d[DW-1:1]};
            CYL_ADDR:  edit = {d[DW-2:0], d[DW-1]};
            EDOP_ADDR: edit = DW'(d[DW-1:7]);
            default:   edit = d;
        endcase
    endfunction

    // One's-complement +1: the carry out of the top bit wraps back into bit 0.
    function automatic logic [DW-1:0] ones_inc(input logic [DW-1:0] d);
        logic [DW:0] s;
        s = {1'b0, d} + (DW+1)'(1);
        ones_inc = s[DW-1:0] + DW'(s[DW]);
    endfunction

    assign accept     = req_valid && req_ready;
    assign req_oor    = req_addr > TOP_ADDR;
    assign req_fixed  = req_addr[AW-1 -: 2] != 2'b00;
    assign req_zero   = req_addr == ZERO_ADDR;
    assign req_stores = (req_op == OP_WRITE) || (req_op == OP_INC);
    assign req_edited = edit(req_addr, req_wdata);

    assign cap_value  = (zero_q || oor_q) ? '0 : mem_rdata;
    assign inc_value  = edit(addr_q, ones_inc(cap_value));

    // Outputs come from registered state only; reset gates them so an abandoned cycle never leaks.
    assign req_ready  = (state == IDLE) && !reset;
    assign rsp_valid  = (state == RSP) && !reset;
    assign rsp_err    = rsp_valid && err_q;
    assign rsp_data   = rsp_data_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = (state == WR) && !suppress_q && !reset;

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (req_op == OP_WRITE) ? WR : RD;
            RD:      next_state = CAP;
            CAP:     next_state = is_inc_q ? WR : RSP;
            WR:      next_state = RSP;
            RSP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            is_inc_q   <= 1'b0;
            oor_q      <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            suppress_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q     <= req_addr;
                is_inc_q   <= req_op == OP_INC;
                oor_q      <= req_oor;
                zero_q     <= req_zero;
                err_q      <= req_oor || (req_fixed && req_stores);
                suppress_q <= req_oor || req_fixed || req_zero;
                wdata_q    <= req_edited;
                rsp_data_q <= (req_op == OP_WRITE && !req_oor) ? req_edited : '0;
            end
            if (state == CAP) begin
                if (is_inc_q) wdata_q <= inc_value;
                rsp_data_q <= oor_q ? '0 : (is_inc_q ? inc_value : cap_value);
            end
        end
    end

endmodule

// File: tb/tb_agc_mem_sequencer.sv
// Scoreboard bench for agc_mem_sequencer: a behavioural model predicts responses and memory writes,
// independent monitors compare them against what the sequencer presents.
module tb_agc_mem_sequencer;

    localparam int AW      = 12;
    localparam int DW      = 15;
    localparam int MEM_TOP = 2046;

    typedef struct {int data; int err; int acc; int lat;} exp_t;
    typedef struct {int addr; int data;} wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   ref_mem [0:4095];
    bit [DW-1:0] env_mem [0:4095];
    exp_t mon_e;
    wr_t  mon_w;

    agc_mem_sequencer #(.AW(AW), .DW(DW), .MEM_TOP(MEM_TOP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with registered read data, as the sequencer expects.
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int ref_edit(input int a, input int v);
        case (a)
            16:      return (v >> 1) | ((v & 1) << 14);
            17:      return (v >> 1) | (v & 'h4000);
            18:      return ((v << 1) & 'h7fff) | (v >> 14);
            19:      return v >> 7;
            default: return v;
        endcase
    endfunction

    function automatic int ref_inc(input int v);
        int s;
        s = v + 1;
        if (s > 'h7fff) s = s - 'h7fff;
        return s;
    endfunction

    task automatic model(input int op, input int addr, input int wd);
        exp_t e;
        bit oor, fixed, zero;
        int cur, val;
        oor   = addr > MEM_TOP;
        fixed = addr >= 1024;
        zero  = addr == 7;
        e.acc = cyc;
        if (op == 1 || op == 2) begin
            if (op == 1) begin
                val   = ref_edit(addr, wd);
                e.lat = 1;
            end else begin
                cur   = (oor || zero) ? 0 : ref_mem[addr];
                val   = ref_edit(addr, ref_inc(cur));
                e.lat = 3;
            end
            e.data = oor ? 0 : val;
            e.err  = (oor || fixed) ? 1 : 0;
            if (!(oor || fixed || zero)) begin
                ref_mem[addr] = val;
                wr_q.push_back('{addr, val});
            end
        end else begin
            e.data = (oor || zero) ? 0 : ref_mem[addr];
            e.err  = oor ? 1 : 0;
            e.lat  = 2;
        end
        exp_q.push_back(e);
    endtask

    // Called one time unit after a rising edge; returns one time unit after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input bit track);
        int n;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (track) model(int'(op), int'(addr), int'(wd));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail_now("drain_timeout");
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 5))
            0:       return int'($urandom_range(16, 19));
            1:       return 7;
            2:       return int'($urandom_range(0, 40));
            3:       return int'($urandom_range(1020, 1028));
            4:       return int'($urandom_range(2040, 2055));
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    // Response and memory-write monitor, independent of the stimulus process.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_rsp");
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), mon_e.data);
                check("rsp_err", 32'(rsp_err), mon_e.err);
                check("rsp_latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                fail_now("unexpected_mem_we");
            end else begin
                mon_w = wr_q.pop_front();
                check("mem_addr", 32'(mem_addr), mon_w.addr);
                check("mem_wdata", 32'(mem_wdata), mon_w.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_err", 32'(rsp_err), 0);
        check("reset_mem_we", 32'(mem_we), 0);
        check("reset_rsp_data", 32'(rsp_data), 0);
        check("reset_mem_addr", 32'(mem_addr), 0);
        check("reset_mem_wdata", 32'(mem_wdata), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(req_ready), 1);

        // Plain write and read-back.
        issue(2'b01, 12'o100, 15'o12345, 1);
        issue(2'b00, 12'o100, '0, 1);

        // Editing registers, then read back.
        for (int a = 16; a <= 19; a++) issue(2'b01, AW'(a), 15'o40001, 1);
        for (int a = 16; a <= 19; a++) issue(2'b00, AW'(a), '0, 1);

        // Increment with end-around carry and without.
        issue(2'b01, 12'o200, 15'o77777, 1);
        issue(2'b01, 12'o201, 15'o37777, 1);
        issue(2'b10, 12'o200, '0, 1);
        issue(2'b10, 12'o201, '0, 1);
        issue(2'b00, 12'o200, '0, 1);
        issue(2'b00, 12'o201, '0, 1);

        // Zero register, fixed memory, out of range, reserved op.
        issue(2'b01, 12'o7, 15'o55555, 1);
        issue(2'b00, 12'o7, '0, 1);
        issue(2'b01, 12'o2000, 15'o11111, 1);
        issue(2'b00, 12'd2047, '0, 1);
        issue(2'b00, 12'o2000, '0, 1);
        issue(2'b10, 12'd2046, '0, 1);
        issue(2'b11, 12'o100, '0, 1);
        drain();

        // Reset during the capture cycle of an increment abandons it.
        issue(2'b01, 12'o300, 15'o01234, 1);
        drain();
        issue(2'b10, 12'o300, '0, 0);
        @(posedge clk); #1;
        check("cap_mem_we", 32'(mem_we), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_in_reset", 32'(req_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ready_after_abort", 32'(req_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        issue(2'b00, 12'o300, '0, 1);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            issue(2'($urandom_range(0, 3)), AW'(pick_addr()), DW'($urandom), 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
